// File: rtl/spi_mem_loader.sv
// Serial load-link receiver: deserialises 12-bit addr/data frames into imem or dmem writes and reports load-done/halt.
// Optional LOADER_CHECKSUM_EN adds load_sum, a modulo-256 sum of committed data since load_done was last cleared.
module spi_mem_loader #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 12,
    parameter int LAST_ADDR   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_in,
    input  logic       mosi_in,
    input  logic [1:0] mode_in,
    input  logic       halt_in,
    output logic       imem_we,
    output logic       dmem_we,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       run_out,
    output logic       done_out,
`ifdef LOADER_CHECKSUM_EN
    output logic [7:0] load_sum,
`endif
    output logic       frame_err
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);
    localparam logic [1:0] MODE_GAP  = 2'b00;
    localparam logic [1:0] MODE_IMEM = 2'b01;
    localparam logic [1:0] MODE_DMEM = 2'b10;
    localparam logic [1:0] MODE_RUN  = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, RUN} state_t;
    state_t state, state_next;

    // All three inputs share one depth so sclk edges stay aligned with mosi and mode.
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, mode0_sync, mode1_sync;
    logic                   sclk_d;
    logic                   sclk_s, mosi_s, sclk_rise;
    logic [1:0]             mode_s;

    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] sr;
    logic [1:0]            cur_mem;
    logic                  load_done;
    logic                  halt_q;

    logic enter_load, do_shift, do_commit, err, clr_done;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign mode_s    = {mode1_sync[SYNC_STAGES-1], mode0_sync[SYNC_STAGES-1]};
    assign sclk_rise = sclk_s & ~sclk_d;
    assign done_out  = (state == RUN) ? halt_q : load_done;

    always_comb begin
        state_next = state;
        enter_load = 1'b0;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        err        = 1'b0;
        clr_done   = 1'b0;
        case (state)
            IDLE: begin
                if (mode_s == MODE_IMEM || mode_s == MODE_DMEM) begin
                    state_next = SHIFT;
                    enter_load = 1'b1;
                    clr_done   = (mode_s != cur_mem);
                end else if (mode_s == MODE_RUN) begin
                    state_next = RUN;
                    clr_done   = 1'b1;
                end
            end
            SHIFT: begin
                if (mode_s == MODE_GAP) begin
                    if (bit_cnt == FULL) begin
                        state_next = COMMIT;
                    end else begin
                        err        = 1'b1;
                        state_next = IDLE;
                    end
                end else if (mode_s != cur_mem) begin
                    // Mode jumped mid-frame: drop it and let IDLE re-evaluate next cycle.
                    err        = 1'b1;
                    state_next = IDLE;
                end else if (sclk_rise && bit_cnt < FULL) begin
                    do_shift = 1'b1;
                end
            end
            COMMIT: begin
                do_commit  = 1'b1;
                state_next = IDLE;
            end
            RUN: begin
                clr_done = 1'b1;
                if (mode_s == MODE_GAP) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            mode0_sync <= '0;
            mode1_sync <= '0;
            sclk_d     <= 1'b0;
            state      <= IDLE;
            bit_cnt    <= '0;
            sr         <= '0;
            cur_mem    <= MODE_GAP;
            load_done  <= 1'b0;
            halt_q     <= 1'b0;
            imem_we    <= 1'b0;
            dmem_we    <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            run_out    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            mode0_sync <= {mode0_sync[SYNC_STAGES-2:0], mode_in[0]};
            mode1_sync <= {mode1_sync[SYNC_STAGES-2:0], mode_in[1]};
            sclk_d     <= sclk_s;
            state      <= state_next;
            if (enter_load) begin
                cur_mem <= mode_s;
                bit_cnt <= '0;
            end
            if (do_shift) begin
                sr      <= {mosi_s, sr[FRAME_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            imem_we <= do_commit && (cur_mem == MODE_IMEM);
            dmem_we <= do_commit && (cur_mem == MODE_DMEM);
            if (do_commit) begin
                wr_addr <= sr[3:0];
                wr_data <= sr[FRAME_BITS-1:4];
            end
            if (clr_done) load_done <= 1'b0;
            else if (do_commit && sr[3:0] == 4'(LAST_ADDR)) load_done <= 1'b1;
            frame_err <= err;
            run_out   <= (state == RUN) && (mode_s != MODE_GAP);
            halt_q    <= (state == RUN) ? halt_in : 1'b0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || clr_done) load_sum <= '0;
        else if (imem_we || dmem_we) load_sum <= load_sum + wr_data;
    end
`endif
endmodule
